// File: rtl/i2s_rx_param.sv
`timescale 1ns/1ps
// i2s_rx_param: I2S / left-justified receiver oversampled in the clk domain, with a paired L/R valid strobe.
// Optional short-slot error counter is enabled by defining I2S_RX_ERR_CNT_EN.
module i2s_rx_param #(
    parameter int DATA_W  = 16,
    parameter int LJ_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bck,
    input  logic              lrck,
    input  logic              dat,
    output logic [DATA_W-1:0] outl,
    output logic [DATA_W-1:0] outr,
    output logic              valid
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [6:0] DW      = 7'(DATA_W);

    logic [2:0] bck_sync_reg;
    logic [1:0] lrck_sync_reg;
    logic [1:0] dat_sync_reg;
    logic       bck_rise;
    logic       lrck_s;
    logic       dat_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_reg  <= '0;
            lrck_sync_reg <= '0;
            dat_sync_reg  <= '0;
        end else begin
            bck_sync_reg  <= {bck_sync_reg[1:0], bck};
            lrck_sync_reg <= {lrck_sync_reg[0], lrck};
            dat_sync_reg  <= {dat_sync_reg[0], dat};
        end
    end

    assign bck_rise = bck_sync_reg[1] & ~bck_sync_reg[2];
    assign lrck_s   = lrck_sync_reg[1];
    assign dat_s    = dat_sync_reg[1];

    logic [0:0]        state_reg;
    logic              primed_reg;
    logic              lrck_prev_reg;
    logic [5:0]        slot_k_reg;
    logic [DATA_W-1:0] word_reg;
    logic              commit_l_reg;
    logic              commit_r_reg;
    logic [DATA_W-1:0] commit_word_reg;
    logic              have_l_reg;

    logic              boundary;
    logic [5:0]        k_next;
    logic [6:0]        bit_n;
    logic              capture;
    logic [DATA_W-1:0] word_next;

    // Slot bit index k for this rise; bit_n wraps to 127 for k=0 in I2S mode, which is never captured.
    always_comb begin
        boundary = (lrck_s != lrck_prev_reg);
        if (boundary)
            k_next = 6'd0;
        else if (slot_k_reg == 6'd63)
            k_next = slot_k_reg;
        else
            k_next = slot_k_reg + 6'd1;
        bit_n   = (LJ_MODE != 0) ? {1'b0, k_next} : ({1'b0, k_next} - 7'd1);
        capture = (bit_n < DW);
    end

    // Bits land at their final left-aligned position, so a short slot leaves zero LSBs.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_word
        assign word_next[DATA_W-1-gi] = (capture && bit_n == 7'(gi)) ? dat_s :
                                        (boundary ? 1'b0 : word_reg[DATA_W-1-gi]);
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [5:0] nbits_reg;
    logic [5:0] nbits_next;
    logic       commit_short_reg;

    assign nbits_next = (boundary ? 6'd0 : nbits_reg) + {5'd0, capture};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_SYNC;
            primed_reg      <= 1'b0;
            lrck_prev_reg   <= 1'b0;
            slot_k_reg      <= '0;
            word_reg        <= '0;
            commit_l_reg    <= 1'b0;
            commit_r_reg    <= 1'b0;
            commit_word_reg <= '0;
`ifdef I2S_RX_ERR_CNT_EN
            nbits_reg        <= '0;
            commit_short_reg <= 1'b0;
`endif
        end else begin
            commit_l_reg <= 1'b0;
            commit_r_reg <= 1'b0;
            if (bck_rise) begin
                lrck_prev_reg <= lrck_s;
                primed_reg    <= 1'b1;
                // The first rise only primes lrck_prev; the next boundary starts the first full slot.
                if (state_reg == ST_RUN || (primed_reg && boundary)) begin
                    state_reg  <= ST_RUN;
                    slot_k_reg <= k_next;
                    word_reg   <= word_next;
`ifdef I2S_RX_ERR_CNT_EN
                    nbits_reg  <= nbits_next;
`endif
                end
                if (state_reg == ST_RUN && boundary) begin
                    commit_l_reg    <= ~lrck_prev_reg;
                    commit_r_reg    <= lrck_prev_reg;
                    commit_word_reg <= word_reg;
`ifdef I2S_RX_ERR_CNT_EN
                    commit_short_reg <= ({1'b0, nbits_reg} < DW);
`endif
                end
            end
        end
    end

    // Output stage: one register after the commit decision gives a fixed 4-clk pin-to-output latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outl       <= '0;
            outr       <= '0;
            valid      <= 1'b0;
            have_l_reg <= 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            valid <= 1'b0;
            if (commit_l_reg) begin
                outl       <= commit_word_reg;
                have_l_reg <= 1'b1;
            end
            if (commit_r_reg) begin
                outr       <= commit_word_reg;
                valid      <= have_l_reg;
                have_l_reg <= 1'b0;
            end
`ifdef I2S_RX_ERR_CNT_EN
            if ((commit_l_reg || commit_r_reg) && commit_short_reg && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_i2s_rx_param.sv
`timescale 1ns/1ps
// Scoreboard bench for i2s_rx_param: three instances (I2S/16, LJ/16, I2S/24) driven by directed slots.
module tb_i2s_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstn_p;
    logic [2:0]  bck_p;
    logic [2:0]  lrck_p;
    logic [2:0]  dat_p;
    logic [15:0] outl0, outr0, outl1, outr1;
    logic [23:0] outl2, outr2;
    logic        valid0, valid1, valid2;
`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0]  err0, err1, err2;
`endif

    int checks   = 0;
    int failures = 0;
    event ev_bnd;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [7:0]  e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    i2s_rx_param #(.DATA_W(16), .LJ_MODE(0)) u_i2s16 (
        .clk(clk), .rst_n(rstn_p[0]), .bck(bck_p[0]), .lrck(lrck_p[0]), .dat(dat_p[0]),
        .outl(outl0), .outr(outr0), .valid(valid0)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_cnt(err0)
`endif
    );

    i2s_rx_param #(.DATA_W(16), .LJ_MODE(1)) u_lj16 (
        .clk(clk), .rst_n(rstn_p[1]), .bck(bck_p[1]), .lrck(lrck_p[1]), .dat(dat_p[1]),
        .outl(outl1), .outr(outr1), .valid(valid1)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_cnt(err1)
`endif
    );

    i2s_rx_param #(.DATA_W(24), .LJ_MODE(0)) u_i2s24 (
        .clk(clk), .rst_n(rstn_p[2]), .bck(bck_p[2]), .lrck(lrck_p[2]), .dat(dat_p[2]),
        .outl(outl2), .outr(outr2), .valid(valid2)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_cnt(err2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    task automatic push_exp(input int inst, input logic [31:0] l, input logic [31:0] r, input logic [7:0] e);
        exp_t t;
        t.l = l;
        t.r = r;
        t.e = e;
        if (inst == 0) q0.push_back(t);
        else if (inst == 1) q1.push_back(t);
        else q2.push_back(t);
    endtask

    // One slot of nbck bit clocks; data and lrck change while bck is low, 4 clk low / 4 clk high.
    task automatic send_slot(input int inst, input logic lr, input logic [31:0] word, input int wbits,
                             input int nbck, input int off, input logic trail, input bit mark);
        int n;
        for (int k = 0; k < nbck; k++) begin
            n = k - off;
            bck_p[inst]  = 1'b0;
            lrck_p[inst] = lr;
            dat_p[inst]  = (n >= 0 && n < wbits) ? word[wbits-1-n] : trail;
            repeat (4) @(posedge clk);
            #1;
            bck_p[inst] = 1'b1;
            if (mark && k == 0) ->ev_bnd;
            repeat (4) @(posedge clk);
            #1;
        end
        bck_p[inst] = 1'b0;
    endtask

    // Monitors: every valid pulse pops one expected pair.
    always @(negedge clk) begin
        if (valid0) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL i2s16_unexpected_valid actual=1 required=0");
            end else begin
                e0 = q0.pop_front();
                chk("i2s16_outl", {16'd0, outl0}, e0.l);
                chk("i2s16_outr", {16'd0, outr0}, e0.r);
`ifdef I2S_RX_ERR_CNT_EN
                chk("i2s16_err_cnt", {24'd0, err0}, {24'd0, e0.e});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL lj16_unexpected_valid actual=1 required=0");
            end else begin
                e1 = q1.pop_front();
                chk("lj16_outl", {16'd0, outl1}, e1.l);
                chk("lj16_outr", {16'd0, outr1}, e1.r);
`ifdef I2S_RX_ERR_CNT_EN
                chk("lj16_err_cnt", {24'd0, err1}, {24'd0, e1.e});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (valid2) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL i2s24_unexpected_valid actual=1 required=0");
            end else begin
                e2 = q2.pop_front();
                chk("i2s24_outl", {8'd0, outl2}, e2.l);
                chk("i2s24_outr", {8'd0, outr2}, e2.r);
`ifdef I2S_RX_ERR_CNT_EN
                chk("i2s24_err_cnt", {24'd0, err2}, {24'd0, e2.e});
`endif
            end
        end
    end

    int vrun0 = 0;
    always @(negedge clk) begin
        if (valid0) begin
            vrun0++;
        end else if (vrun0 > 0) begin
            chk("i2s16_valid_width", vrun0, 1);
            vrun0 = 0;
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rstn_p = 3'b000;
        bck_p  = 3'b000;
        lrck_p = 3'b111;
        dat_p  = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outl", {16'd0, outl0}, 32'h0);
        chk("rst_outr", {16'd0, outr0}, 32'h0);
        chk("rst_valid", {31'd0, valid0}, 32'h0);
        rstn_p = 3'b111;

        // I2S: partial slot, then L=FF7F R=CACA; latency measured from the L->R boundary rise
        push_exp(0, 32'hFF7F, 32'hCACA, 8'd0);
        fork
            begin
                send_slot(0, 1'b1, 32'h0,    16, 5,  1, 1'b0, 1'b0);
                send_slot(0, 1'b0, 32'hFF7F, 16, 18, 1, 1'b0, 1'b0);
                send_slot(0, 1'b1, 32'hCACA, 16, 18, 1, 1'b0, 1'b1);
                send_slot(0, 1'b0, 32'h0,    16, 18, 1, 1'b0, 1'b0);
            end
            begin
                cyc = 0;
                @(ev_bnd);
                while (outl0 == 16'h0 && cyc < 20) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk("latency_clk", cyc, 4);
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // I2S short 12-bck slots: 11 data bits each, both commits count as short
        rstn_p[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn_p[0] = 1'b1;
        push_exp(0, 32'hFFE0, 32'h5540, 8'd2);
        send_slot(0, 1'b1, 32'h0,    16, 5,  1, 1'b0, 1'b0);
        send_slot(0, 1'b0, 32'hFFFF, 16, 12, 1, 1'b0, 1'b0);
        send_slot(0, 1'b1, 32'h5555, 16, 12, 1, 1'b0, 1'b0);
        send_slot(0, 1'b0, 32'h0,    16, 18, 1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // Reset in the middle of a left slot while outputs hold non-zero values
        send_slot(0, 1'b0, 32'h1111, 16, 6, 1, 1'b0, 1'b0);
        rstn_p[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_outl", {16'd0, outl0}, 32'h0);
        chk("midrst_outr", {16'd0, outr0}, 32'h0);
        chk("midrst_valid", {31'd0, valid0}, 32'h0);
`ifdef I2S_RX_ERR_CNT_EN
        chk("midrst_err_cnt", {24'd0, err0}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rstn_p[0] = 1'b1;
        send_slot(0, 1'b0, 32'h1111, 16, 12, 1, 1'b0, 1'b0);
        send_slot(0, 1'b1, 32'h2222, 16, 18, 1, 1'b0, 1'b0);
        send_slot(0, 1'b0, 32'h3333, 16, 18, 1, 1'b0, 1'b0);
        chk("orphan_right_outr", {16'd0, outr0}, 32'h2222);
        chk("orphan_right_outl", {16'd0, outl0}, 32'h0);
        push_exp(0, 32'h3333, 32'h4444, 8'd0);
        push_exp(0, 32'h5555, 32'h6666, 8'd0);
        send_slot(0, 1'b1, 32'h4444, 16, 18, 1, 1'b0, 1'b0);
        send_slot(0, 1'b0, 32'h5555, 16, 18, 1, 1'b0, 1'b0);
        send_slot(0, 1'b1, 32'h6666, 16, 18, 1, 1'b0, 1'b0);
        send_slot(0, 1'b0, 32'h0,    16, 18, 1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // Left-justified, 16-bck slots
        push_exp(1, 32'h1234, 32'h8001, 8'd0);
        send_slot(1, 1'b1, 32'h0,    16, 5,  0, 1'b0, 1'b0);
        send_slot(1, 1'b0, 32'h1234, 16, 16, 0, 1'b0, 1'b0);
        send_slot(1, 1'b1, 32'h8001, 16, 16, 0, 1'b0, 1'b0);
        send_slot(1, 1'b0, 32'h0,    16, 16, 0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // 24-bit I2S, 32-bck slots with ones after the LSB
        push_exp(2, 32'hABCDEF, 32'h000001, 8'd0);
        send_slot(2, 1'b1, 32'h0,      24, 5,  1, 1'b1, 1'b0);
        send_slot(2, 1'b0, 32'hABCDEF, 24, 32, 1, 1'b1, 1'b0);
        send_slot(2, 1'b1, 32'h000001, 24, 32, 1, 1'b1, 1'b0);
        send_slot(2, 1'b0, 32'h0,      24, 32, 1, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        chk("q_i2s16_drained", q0.size(), 0);
        chk("q_lj16_drained",  q1.size(), 0);
        chk("q_i2s24_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
